// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: word width, fetch-state
// encodings and the instruction field bounds used for next-PC computation.
package instr_fetch_unit_pkg;

    localparam int unsigned IFU_WORD_SIZE = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    // Signed branch offset and absolute jump-target fields within instr
    localparam int unsigned BR_OFF_MSB  = 7;
    localparam int unsigned BR_OFF_LSB  = 0;
    localparam int unsigned BR_OFF_W    = BR_OFF_MSB - BR_OFF_LSB + 1;
    localparam int unsigned JMP_TGT_MSB = 11;
    localparam int unsigned JMP_TGT_LSB = 0;

endpackage

// File: rtl/instr_fetch_unit_next_pc_calc.sv
// Combinational next-PC selection: register jump, in-page jump, taken branch,
// or sequential, in that priority order. All arithmetic wraps at WORD_SIZE.
module next_pc_calc
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned WORD_SIZE = IFU_WORD_SIZE
) (
    input  logic [WORD_SIZE-1:0] pc,
    input  logic [WORD_SIZE-1:0] instr,
    input  logic                 jp,
    input  logic                 jp_reg,
    input  logic [WORD_SIZE-1:0] reg_target,
    input  logic                 branch,
    input  logic                 branch_taken,
    output logic [WORD_SIZE-1:0] next_pc
);

    logic [WORD_SIZE-1:0] w_pc_plus1;
    logic [WORD_SIZE-1:0] w_br_off;
    logic [WORD_SIZE-1:0] w_br_target;
    logic [WORD_SIZE-1:0] w_jmp_target;

    assign w_pc_plus1   = pc + WORD_SIZE'(1);
    assign w_br_off     = {{(WORD_SIZE-BR_OFF_W){instr[BR_OFF_MSB]}},
                           instr[BR_OFF_MSB:BR_OFF_LSB]};
    assign w_br_target  = w_pc_plus1 + w_br_off;
    // Jump keeps the current page (upper PC bits) and replaces the low field
    assign w_jmp_target = {pc[WORD_SIZE-1:JMP_TGT_MSB+1],
                           instr[JMP_TGT_MSB:JMP_TGT_LSB]};

    always_comb begin
        next_pc = w_pc_plus1;
        if (jp && jp_reg) begin
            next_pc = reg_target;
        end else if (jp) begin
            next_pc = w_jmp_target;
        end else if (branch && branch_taken) begin
            next_pc = w_br_target;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches over the shared memory port,
// holds the instruction for the decoder and advances the PC on retire.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned           WORD_SIZE = IFU_WORD_SIZE,
    parameter logic [WORD_SIZE-1:0]  RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic                 readM,
    output logic [WORD_SIZE-1:0] address,
    input  logic [WORD_SIZE-1:0] data,
    input  logic                 inputReady,
    output logic [WORD_SIZE-1:0] instr,
    output logic                 instr_valid,
    output logic [WORD_SIZE-1:0] pc,
    output logic [WORD_SIZE-1:0] pc_plus1,
    input  logic                 exec_done,
    input  logic                 jp,
    input  logic                 jp_reg,
    input  logic [WORD_SIZE-1:0] reg_target,
    input  logic                 branch,
    input  logic                 branch_taken,
    input  logic                 halt,
    output logic [WORD_SIZE-1:0] num_inst,
    output logic                 halted
);

    fetch_state_t         r_state;
    logic [WORD_SIZE-1:0] r_pc;
    logic [WORD_SIZE-1:0] r_instr;
    logic [WORD_SIZE-1:0] r_num_inst;
    logic                 r_readM;
    logic                 r_instr_valid;
    logic                 r_halted;
    logic [WORD_SIZE-1:0] w_next_pc;

    next_pc_calc #(
        .WORD_SIZE (WORD_SIZE)
    ) u_next_pc_calc (
        .pc           (r_pc),
        .instr        (r_instr),
        .jp           (jp),
        .jp_reg       (jp_reg),
        .reg_target   (reg_target),
        .branch       (branch),
        .branch_taken (branch_taken),
        .next_pc      (w_next_pc)
    );

    // Status outputs are registered alongside the state so they track it exactly
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_pc          <= RESET_PC;
            r_instr       <= '0;
            r_num_inst    <= '0;
            r_readM       <= 1'b0;
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= FETCH;
                    r_readM <= 1'b1;
                end
                FETCH: begin
                    if (inputReady) begin
                        r_instr       <= data;
                        r_state       <= EXEC;
                        r_readM       <= 1'b0;
                        r_instr_valid <= 1'b1;
                    end
                end
                EXEC: begin
                    if (exec_done) begin
                        r_pc          <= w_next_pc;
                        r_num_inst    <= r_num_inst + WORD_SIZE'(1);
                        r_instr_valid <= 1'b0;
                        if (halt) begin
                            r_state  <= HALT;
                            r_halted <= 1'b1;
                        end else begin
                            r_state <= FETCH;
                            r_readM <= 1'b1;
                        end
                    end
                end
                HALT: begin
                    r_state <= HALT;
                end
                default: begin
                    r_state       <= IDLE;
                    r_readM       <= 1'b0;
                    r_instr_valid <= 1'b0;
                    r_halted      <= 1'b0;
                end
            endcase
        end
    end

    assign readM       = r_readM;
    assign address     = r_pc;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign pc          = r_pc;
    assign pc_plus1    = r_pc + WORD_SIZE'(1);
    assign num_inst    = r_num_inst;
    assign halted      = r_halted;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit: fetch/retire sequencing,
// next-PC selection, wrap-around, halt and asynchronous reset behaviour.
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic        readM;
    logic [15:0] address;
    logic [15:0] data;
    logic        inputReady;
    logic [15:0] instr;
    logic        instr_valid;
    logic [15:0] pc;
    logic [15:0] pc_plus1;
    logic        exec_done;
    logic        jp;
    logic        jp_reg;
    logic [15:0] reg_target;
    logic        branch;
    logic        branch_taken;
    logic        halt;
    logic [15:0] num_inst;
    logic        halted;

    int unsigned total = 0;
    int unsigned bad   = 0;

    instr_fetch_unit #(
        .WORD_SIZE (16),
        .RESET_PC  (16'h0000)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .readM        (readM),
        .address      (address),
        .data         (data),
        .inputReady   (inputReady),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .pc           (pc),
        .pc_plus1     (pc_plus1),
        .exec_done    (exec_done),
        .jp           (jp),
        .jp_reg       (jp_reg),
        .reg_target   (reg_target),
        .branch       (branch),
        .branch_taken (branch_taken),
        .halt         (halt),
        .num_inst     (num_inst),
        .halted       (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Caller is positioned 1 time unit after an edge with the DUT in FETCH
    task automatic run_fetch(input logic [15:0] d, input int unsigned lat);
        inputReady = 1'b0;
        data       = ~d;
        for (int unsigned i = 0; i < lat; i++) begin
            @(posedge clk); #1;
        end
        data       = d;
        inputReady = 1'b1;
        @(posedge clk); #1;
        inputReady = 1'b0;
        data       = '0;
    endtask

    // Decoder controls hold misleading values until the retiring edge
    task automatic run_exec(input logic j, input logic jr, input logic [15:0] rt,
                            input logic b, input logic bt, input logic h,
                            input int unsigned lat);
        exec_done = 1'b0;
        jp = 1'b1; jp_reg = 1'b1; reg_target = 16'hDEAD;
        branch = 1'b1; branch_taken = 1'b1; halt = 1'b1;
        for (int unsigned i = 0; i < lat; i++) begin
            @(posedge clk); #1;
        end
        jp = j; jp_reg = jr; reg_target = rt;
        branch = b; branch_taken = bt; halt = h;
        exec_done = 1'b1;
        @(posedge clk); #1;
        exec_done = 1'b0;
        jp = 1'b0; jp_reg = 1'b0; reg_target = '0;
        branch = 1'b0; branch_taken = 1'b0; halt = 1'b0;
    endtask

    task automatic goto_pc(input logic [15:0] target);
        run_fetch(16'h0000, 0);
        run_exec(1'b1, 1'b1, target, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        data = '0; inputReady = 1'b0; exec_done = 1'b0;
        jp = 1'b0; jp_reg = 1'b0; reg_target = '0;
        branch = 1'b0; branch_taken = 1'b0; halt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (readM !== 1'b0) begin bad++; $display("FAIL reset_readM: got %b want 0", readM); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_instr_valid: got %b want 0", instr_valid); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted: got %b want 0", halted); end
        total++; if (pc !== 16'h0000) begin bad++; $display("FAIL reset_pc: got %h want 0000", pc); end
        total++; if (instr !== 16'h0000) begin bad++; $display("FAIL reset_instr: got %h want 0000", instr); end
        total++; if (num_inst !== 16'h0000) begin bad++; $display("FAIL reset_num_inst: got %h want 0000", num_inst); end
    endtask

    task automatic test_sequential();
        reset_n = 1'b1;
        @(posedge clk); #1;
        total++; if (readM !== 1'b1) begin bad++; $display("FAIL seq_fetch_readM: got %b want 1", readM); end
        total++; if (address !== 16'h0000) begin bad++; $display("FAIL seq_fetch_address: got %h want 0000", address); end
        run_fetch(16'h6001, 2);
        total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL seq_instr_valid: got %b want 1", instr_valid); end
        total++; if (instr !== 16'h6001) begin bad++; $display("FAIL seq_instr: got %h want 6001", instr); end
        total++; if (readM !== 1'b0) begin bad++; $display("FAIL seq_exec_readM: got %b want 0", readM); end
        total++; if (pc_plus1 !== 16'h0001) begin bad++; $display("FAIL seq_pc_plus1: got %h want 0001", pc_plus1); end
        run_exec(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1);
        total++; if (pc !== 16'h0001) begin bad++; $display("FAIL seq_pc: got %h want 0001", pc); end
        total++; if (num_inst !== 16'h0001) begin bad++; $display("FAIL seq_num_inst: got %h want 0001", num_inst); end
        total++; if (readM !== 1'b1 || address !== 16'h0001) begin bad++; $display("FAIL seq_next_fetch: got readM=%b addr=%h want readM=1 addr=0001", readM, address); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL seq_valid_drop: got %b want 0", instr_valid); end
    endtask

    task automatic test_ignored_in_fetch();
        exec_done = 1'b1; jp = 1'b1; jp_reg = 1'b1; reg_target = 16'hDEAD; halt = 1'b1;
        inputReady = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exec_done = 1'b0; jp = 1'b0; jp_reg = 1'b0; reg_target = '0; halt = 1'b0;
        total++; if (pc !== 16'h0001 || num_inst !== 16'h0001) begin bad++; $display("FAIL fetch_ignore_exec: got pc=%h n=%h want pc=0001 n=0001", pc, num_inst); end
        total++; if (readM !== 1'b1 || instr_valid !== 1'b0) begin bad++; $display("FAIL fetch_no_timeout: got readM=%b valid=%b want 1 0", readM, instr_valid); end
    endtask

    task automatic test_reg_jump();
        goto_pc(16'hABCD);
        total++; if (pc !== 16'hABCD) begin bad++; $display("FAIL reg_jump_pc: got %h want abcd", pc); end
        total++; if (num_inst !== 16'h0002) begin bad++; $display("FAIL reg_jump_num: got %h want 0002", num_inst); end
    endtask

    task automatic test_jump();
        goto_pc(16'h1234);
        run_fetch(16'h9056, 1);
        run_exec(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 2);
        total++; if (pc !== 16'h1056) begin bad++; $display("FAIL jump_pc: got %h want 1056", pc); end
        total++; if (num_inst !== 16'h0004) begin bad++; $display("FAIL jump_num: got %h want 0004", num_inst); end
        run_fetch(16'h0003, 0);
        run_exec(1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b1, 1'b0, 0);
        total++; if (pc !== 16'h1003) begin bad++; $display("FAIL jump_over_branch: got %h want 1003", pc); end
        run_fetch(16'h0007, 0);
        run_exec(1'b1, 1'b1, 16'h2222, 1'b1, 1'b1, 1'b0, 0);
        total++; if (pc !== 16'h2222) begin bad++; $display("FAIL regjump_over_branch: got %h want 2222", pc); end
    endtask

    task automatic test_branch();
        goto_pc(16'h0010);
        run_fetch(16'h40FE, 0);
        run_exec(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 0);
        total++; if (pc !== 16'h000F) begin bad++; $display("FAIL branch_taken_back: got %h want 000f", pc); end
        goto_pc(16'h0010);
        run_fetch(16'h40FE, 0);
        run_exec(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 0);
        total++; if (pc !== 16'h0011) begin bad++; $display("FAIL branch_not_taken: got %h want 0011", pc); end
        run_fetch(16'h40FE, 0);
        run_exec(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 0);
        total++; if (pc !== 16'h0012) begin bad++; $display("FAIL taken_without_branch: got %h want 0012", pc); end
        goto_pc(16'h0000);
        run_fetch(16'h00F0, 0);
        run_exec(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 0);
        total++; if (pc !== 16'hFFF1) begin bad++; $display("FAIL branch_wrap_below0: got %h want fff1", pc); end
        run_fetch(16'h007F, 0);
        run_exec(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 0);
        total++; if (pc !== 16'h0071) begin bad++; $display("FAIL branch_wrap_fwd: got %h want 0071", pc); end
        goto_pc(16'hFFFF);
        run_fetch(16'h0000, 0);
        total++; if (pc_plus1 !== 16'h0000) begin bad++; $display("FAIL pc_plus1_wrap: got %h want 0000", pc_plus1); end
        run_exec(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 0);
        total++; if (pc !== 16'h0000) begin bad++; $display("FAIL seq_wrap: got %h want 0000", pc); end
        total++; if (num_inst !== 16'h0010) begin bad++; $display("FAIL branch_num: got %h want 0010", num_inst); end
    endtask

    task automatic test_back_to_back();
        data = 16'h1111; inputReady = 1'b1; exec_done = 1'b1;
        for (int unsigned i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            total++; if (instr_valid !== 1'b1 || pc !== 16'(i - 1)) begin bad++; $display("FAIL b2b_exec%0d: got valid=%b pc=%h want 1 %h", i, instr_valid, pc, 16'(i - 1)); end
            @(posedge clk); #1;
            total++; if (pc !== 16'(i) || readM !== 1'b1) begin bad++; $display("FAIL b2b_retire%0d: got pc=%h readM=%b want %h 1", i, pc, readM, 16'(i)); end
        end
        inputReady = 1'b0; exec_done = 1'b0; data = '0;
        total++; if (num_inst !== 16'h0013) begin bad++; $display("FAIL b2b_num: got %h want 0013", num_inst); end
    endtask

    task automatic test_reset_mid_fetch();
        goto_pc(16'h0020);
        total++; if (pc !== 16'h0020 || readM !== 1'b1) begin bad++; $display("FAIL pre_reset_fetch: got pc=%h readM=%b want 0020 1", pc, readM); end
        #2;
        reset_n = 1'b0;
        #1;
        total++; if (readM !== 1'b0 || pc !== 16'h0000) begin bad++; $display("FAIL async_reset: got readM=%b pc=%h want 0 0000", readM, pc); end
        total++; if (num_inst !== 16'h0000) begin bad++; $display("FAIL async_reset_num: got %h want 0000", num_inst); end
        @(posedge clk); #1;
        reset_n = 1'b1; data = 16'hBEEF; inputReady = 1'b1;
        @(posedge clk); #1;
        inputReady = 1'b0;
        total++; if (instr_valid !== 1'b0 || instr !== 16'h0000) begin bad++; $display("FAIL stale_ready: got valid=%b instr=%h want 0 0000", instr_valid, instr); end
        total++; if (readM !== 1'b1 || address !== 16'h0000) begin bad++; $display("FAIL refetch: got readM=%b addr=%h want 1 0000", readM, address); end
        @(posedge clk); #1;
        total++; if (readM !== 1'b1 || instr_valid !== 1'b0) begin bad++; $display("FAIL fetch_waits: got readM=%b valid=%b want 1 0", readM, instr_valid); end
    endtask

    task automatic test_halt();
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        for (int unsigned i = 0; i < 4; i++) begin
            run_fetch(16'h0000, 0);
            run_exec(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 0);
        end
        total++; if (num_inst !== 16'h0004) begin bad++; $display("FAIL pre_halt_num: got %h want 0004", num_inst); end
        run_fetch(16'h000F, 0);
        run_exec(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 0);
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL halted: got %b want 1", halted); end
        total++; if (num_inst !== 16'h0005 || pc !== 16'h0005) begin bad++; $display("FAIL halt_retire: got n=%h pc=%h want 0005 0005", num_inst, pc); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL halt_valid: got %b want 0", instr_valid); end
        for (int unsigned i = 0; i < 20; i++) begin
            inputReady = i[0]; exec_done = ~i[0]; data = 16'h5A5A;
            jp = 1'b1; jp_reg = 1'b1; reg_target = 16'h7777;
            @(posedge clk); #1;
            total++; if (readM !== 1'b0 || halted !== 1'b1 || pc !== 16'h0005 || num_inst !== 16'h0005) begin bad++; $display("FAIL halt_hold%0d: got readM=%b halted=%b pc=%h n=%h want 0 1 0005 0005", i, readM, halted, pc, num_inst); end
        end
        inputReady = 1'b0; exec_done = 1'b0; jp = 1'b0; jp_reg = 1'b0; reg_target = '0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_ignored_in_fetch();
        test_reg_jump();
        test_jump();
        test_branch();
        test_back_to_back();
        test_reset_mid_fetch();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream neighbour of the instruction decoder/control unit in the 16-bit TSC-style CPU.
- Owns the PC and drives instruction reads on the shared memory port (readM/address/data/inputReady).
- Holds the fetched word stable on instr for the decoder while the datapath executes it.
- Computes the next PC from decoder/datapath results (jump, register jump, taken branch, sequential), counts retired instructions, and stops on halt.

Parameters:
- WORD_SIZE, 16, width of instructions, PC and data.
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- readM  output  1  instruction read request to memory.
- address  output  WORD_SIZE  memory address for the read; equals pc.
- data  input  WORD_SIZE  memory read data; valid when inputReady=1.
- inputReady  input  1  memory read-complete strobe.
- instr  output  WORD_SIZE  latched instruction, fed to the decoder.
- instr_valid  output  1  instr holds an instruction under execution.
- pc  output  WORD_SIZE  address of the instruction in instr.
- pc_plus1  output  WORD_SIZE  pc+1, used as the link value for JAL/JRL.
- exec_done  input  1  datapath has finished the current instruction.
- jp  input  1  decoder: jump instruction.
- jp_reg  input  1  jump target comes from a register (JPR/JRL).
- reg_target  input  WORD_SIZE  register jump target.
- branch  input  1  decoder: branch instruction.
- branch_taken  input  1  datapath branch-condition result.
- halt  input  1  current instruction is HLT.
- num_inst  output  WORD_SIZE  retired-instruction counter.
- halted  output  1  fetch permanently stopped.

Behaviour:
- Reset: async on reset_n=0. Outputs and registers take these values immediately:
  - state=IDLE, pc=RESET_PC, instr=16'h0000, num_inst=0.
  - readM=0, instr_valid=0, halted=0.
  - A fetch in flight when reset asserts is abandoned; a late inputReady is ignored.
- States: IDLE, FETCH, EXEC, HALT.
  - IDLE -> FETCH on the first rising edge after reset_n deasserts.
  - FETCH: readM=1, address=pc. On an edge with inputReady=1: instr<=data, go to EXEC. Otherwise stay in FETCH, with no timeout.
  - EXEC: instr_valid=1, readM=0; instr and pc are held stable. On an edge with exec_done=1:
    - pc<=next_pc and num_inst<=num_inst+1.
    - If halt=1, go to HALT; otherwise go to FETCH.
  - HALT: halted=1, readM=0, instr_valid=0. pc and num_inst are frozen. Exit is by reset only.
- next_pc, priority order:
  - jp & jp_reg: reg_target.
  - jp: {pc[15:12], instr[11:0]}.
  - branch & branch_taken: pc + 1 + sign_extend(instr[7:0]).
  - otherwise: pc + 1.
  - halt has no effect on next_pc; pc still advances on retire.
- Arithmetic: all modulo 2^16. pc=16'hFFFF sequential wraps to 16'h0000. A backward branch below 0 wraps. num_inst wraps from 16'hFFFF to 0.
- Ignored inputs:
  - inputReady outside FETCH.
  - exec_done outside EXEC.
  - jp/branch/branch_taken/halt/reg_target except on the retiring edge.
- Simultaneous inputReady and exec_done: only the one matching the current state acts.
- Latency:
  - Minimum per instruction is 2 cycles: 1 FETCH cycle with immediate inputReady, plus 1 EXEC cycle with immediate exec_done.
  - instr_valid rises the cycle after the inputReady edge.
- Outputs readM, instr_valid, halted and address are Moore outputs, decoded from state and pc only.

Decomposition:
- Shared package/header (alongside opcodes.v):
  - WORD_SIZE.
  - Fetch-state encodings: IDLE=2'd0, FETCH=2'd1, EXEC=2'd2, HALT=2'd3.
  - Branch-offset field bounds [7:0] and jump-target field bounds [11:0].
- Sub-module next_pc_calc: combinational; inputs pc, instr, jp, jp_reg, reg_target, branch, branch_taken; output next_pc. It is testable standalone.

Test Plan:
- Sequential fetch:
  - Stimulus: reset, mem[0]=16'h6001, inputReady after 2 cycles, exec_done after 1 cycle.
  - Required: address=0 with readM=1; instr=16'h6001 with instr_valid=1; then pc=1, num_inst=1, readM=1, address=1.
- Jump:
  - Stimulus: pc=16'h1234, instr=16'h9056, jp=1, jp_reg=0, exec_done.
  - Required: pc=16'h1056.
- Register jump:
  - Stimulus: jp=1, jp_reg=1, reg_target=16'hABCD.
  - Required: pc=16'hABCD.
- Branches, with pc=16'h0010:
  - instr[7:0]=8'hFE, branch_taken=1 -> pc=16'h000F.
  - Same with branch_taken=0 -> pc=16'h0011.
  - pc=16'hFFFF sequential -> pc=0.
- Halt:
  - Stimulus: halt=1 with exec_done at num_inst=4.
  - Required: halted=1, num_inst=5, readM stays 0 for 20 cycles; inputReady and exec_done pulses have no effect.
- Reset mid-fetch:
  - Stimulus: assert reset_n=0 asynchronously while in FETCH with pc=16'h0020.
  - Required: readM=0 and pc=RESET_PC before the next clk edge; a stale inputReady after release is ignored until FETCH is re-entered.
